// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// button_debounce : active-low button synchroniser/debouncer with press and
//                   release pulses, one independent channel per button.
// Revision        : 1.0
// ============================================================================
module button_debounce #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_n_in,
   output logic [N_BTN-1:0] pressed,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Sync flops reset to 1 so a released (high) pin looks idle out of reset.
   logic [N_BTN-1:0] sync1;
   logic [N_BTN-1:0] sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= btn_n_in;
         sync2 <= sync1;
      end
   end

   generate
      for (genvar i = 0; i < N_BTN; i++) begin : g_ch
         logic             s;
         logic [CNT_W-1:0] cnt;
         logic             lvl;
         logic             pp;
         logic             rp;

         assign s = ~sync2[i];

         // The level flips only after DEBOUNCE_CYCLES consecutive differing
         // samples; pulses are registered on the same edge as the flip.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt <= '0;
               lvl <= 1'b0;
               pp  <= 1'b0;
               rp  <= 1'b0;
            end else begin
               pp <= 1'b0;
               rp <= 1'b0;
               if (s == lvl) begin
                  cnt <= '0;
               end else if (cnt == LAST_CNT) begin
                  cnt <= '0;
                  lvl <= s;
                  pp  <= s;
                  rp  <= ~s;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
         end

         assign pressed[i]       = lvl;
         assign press_pulse[i]   = pp;
         assign release_pulse[i] = rp;
      end
   endgenerate

endmodule
`default_nettype wire
